// File: rtl/wb_ram_burst_if.sv
// Wishbone B4 classic bus bundle between a master and the burst-capable RAM slave.
// Carries no logic, so it adds no latency.
// The slave stalls the master only by withholding ack/err.
interface wb_ram_burst_if #(
    parameter int DAT_WIDTH = 32,
    parameter int ADR_WIDTH = 11
);
    logic                   wb_cyc_i;
    logic                   wb_stb_i;
    logic                   wb_we_i;
    logic [ADR_WIDTH-1:0]   wb_adr_i;
    logic [DAT_WIDTH/8-1:0] wb_sel_i;
    logic [DAT_WIDTH-1:0]   wb_dat_i;
    logic [2:0]             wb_cti_i;
    logic [1:0]             wb_bte_i;
    logic [DAT_WIDTH-1:0]   wb_dat_o;
    logic                   wb_ack_o;
    logic                   wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_ram_burst.sv
// Single-port Wishbone RAM with byte enables and incrementing/wrapping bursts.
// First beat acked 1 cycle after request; further burst beats at one per clock.
// Master is held off only by the registered ack/err; writes commit in the ack cycle.
module wb_ram_burst #(
    parameter int DAT_WIDTH = 32,
    parameter int ADR_WIDTH = 11,
    parameter int MEM_SIZE  = 2048,
    parameter     INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         rst,
    wb_ram_burst_if.slave wb
);
    localparam int NB = DAT_WIDTH / 8;
    localparam logic [ADR_WIDTH:0] MEM_LIMIT = (ADR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [DAT_WIDTH-1:0] dat_q;
    logic                 rd_en, dat_clr, wr_en;
    logic [ADR_WIDTH-1:0] rd_adr;
    logic [ADR_WIDTH-1:0] adr_inc, wrap_mask, nxt_adr;
    logic                 req;

    logic [DAT_WIDTH-1:0] ram [MEM_SIZE];

    function automatic logic in_range(input logic [ADR_WIDTH-1:0] a);
        return {1'b0, a} < MEM_LIMIT;
    endfunction

    assign req     = wb.wb_cyc_i & wb.wb_stb_i;
    assign adr_inc = wb.wb_adr_i + ADR_WIDTH'(1);

    // Wrapping bursts only carry into the low bits of the aligned block.
    always_comb begin
        wrap_mask = '1;
        case (wb.wb_bte_i)
            2'b01:   wrap_mask = ADR_WIDTH'(4'h3);
            2'b10:   wrap_mask = ADR_WIDTH'(4'h7);
            2'b11:   wrap_mask = ADR_WIDTH'(4'hF);
            default: wrap_mask = '1;
        endcase
        nxt_adr = (wb.wb_adr_i & ~wrap_mask) | (adr_inc & wrap_mask);
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        dat_clr = 1'b0;
        wr_en   = 1'b0;
        rd_adr  = wb.wb_adr_i;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACTIVE;
                    if (in_range(wb.wb_adr_i)) begin
                        ack_d = 1'b1;
                        rd_en = ~wb.wb_we_i;
                    end else begin
                        err_d   = 1'b1;
                        dat_clr = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                wr_en = ack_q & wb.wb_we_i & in_range(wb.wb_adr_i);
                if (req && wb.wb_cti_i == 3'b010 && !err_q) begin
                    rd_adr = nxt_adr;
                    if (in_range(nxt_adr)) begin
                        ack_d = 1'b1;
                        rd_en = ~wb.wb_we_i;
                    end else begin
                        err_d   = 1'b1;
                        dat_clr = ~wb.wb_we_i;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (dat_clr)
                dat_q <= '0;
            else if (rd_en)
                dat_q <= ram[rd_adr];
        end
    end

    // RAM contents survive reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int n = 0; n < NB; n++) begin
                if (wb.wb_sel_i[n])
                    ram[wb.wb_adr_i][8*n +: 8] <= wb.wb_dat_i[8*n +: 8];
            end
        end
    end

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
endmodule

// File: tb/tb_wb_ram_burst.sv
// Bench for wb_ram_burst: directed scenarios then random bursts, all checked against
// a word-array memory model with plain address arithmetic.
module tb_wb_ram_burst;
    localparam int MSIZE = 1000;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] mem   [1024];
    logic [31:0] bdat  [1024];
    logic [3:0]  bsel  [1024];

    wb_ram_burst_if #(.DAT_WIDTH(32), .ADR_WIDTH(AW)) bus ();

    wb_ram_burst #(.DAT_WIDTH(32), .ADR_WIDTH(AW), .MEM_SIZE(MSIZE), .INIT_FILE("")) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int next_adr(input int a, input int bte);
        int sz;
        sz = (bte == 1) ? 4 : (bte == 2) ? 8 : (bte == 3) ? 16 : 1024;
        return (a - (a % sz)) + ((a + 1) % sz);
    endfunction

    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
        for (int n = 0; n < 4; n++)
            if (s[n]) mem[a][8*n +: 8] = d[8*n +: 8];
    endtask

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cti_i = 3'b000;
    endtask

    // One transaction of len beats; beat i uses bdat[i]/bsel[i] for writes.
    task automatic run(input bit we, input int start, input int len, input int bte,
                       input bit classic, input string tag);
        int a;
        bit ok;
        a = start;
        for (int i = 0; i < len; i++) begin
            bus.wb_cyc_i = 1'b1;
            bus.wb_stb_i = 1'b1;
            bus.wb_we_i  = we;
            bus.wb_adr_i = AW'(a);
            bus.wb_sel_i = bsel[i];
            bus.wb_dat_i = bdat[i];
            bus.wb_bte_i = 2'(bte);
            bus.wb_cti_i = classic ? 3'b000 : (i == len - 1) ? 3'b111 : 3'b010;
            if (i == 0) tick();
            ok = (a < MSIZE);
            chk({tag, "_ack"}, 32'(bus.wb_ack_o), 32'(ok));
            chk({tag, "_err"}, 32'(bus.wb_err_o), 32'(!ok));
            if (!we) chk({tag, "_dat"}, bus.wb_dat_o, ok ? mem[a] : 32'h0);
            if (we && ok) model_write(a, bdat[i], bsel[i]);
            tick();
            if (!ok) break;
            a = next_adr(a, bte);
        end
        idle_bus();
        chk({tag, "_end_ack"}, 32'(bus.wb_ack_o), 32'h0);
        chk({tag, "_end_err"}, 32'(bus.wb_err_o), 32'h0);
    endtask

    initial begin
        idle_bus();
        bus.wb_adr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_bte_i = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        chk("rst_err", 32'(bus.wb_err_o), 32'h0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);

        // Known contents everywhere via one long linear write burst.
        for (int i = 0; i < MSIZE; i++) begin
            bdat[i] = $urandom;
            bsel[i] = 4'hF;
        end
        run(1'b1, 0, MSIZE, 0, 1'b0, "fill");
        run(1'b0, 990, 10, 0, 1'b0, "fill_rd");

        bdat[0] = 32'hA5A5_1234; bsel[0] = 4'hF;
        run(1'b1, 5, 1, 0, 1'b1, "t1_wr");
        run(1'b0, 5, 1, 0, 1'b1, "t1_rd");
        chk("t1_hold", bus.wb_dat_o, 32'hA5A5_1234);

        bdat[0] = 32'hFFFF_FFFF; bsel[0] = 4'hF;
        run(1'b1, 7, 1, 0, 1'b1, "t2_wr1");
        bdat[0] = 32'h0000_0000; bsel[0] = 4'b0101;
        run(1'b1, 7, 1, 0, 1'b1, "t2_wr2");
        run(1'b0, 7, 1, 0, 1'b1, "t2_rd");
        chk("t2_val", bus.wb_dat_o, 32'hFF00_FF00);

        for (int i = 0; i < 4; i++) begin
            bdat[i] = 32'(10 + i);
            bsel[i] = 4'hF;
        end
        run(1'b1, 10, 4, 0, 1'b0, "t3_wr");
        run(1'b0, 10, 4, 0, 1'b0, "t3_rd");
        chk("t3_last", bus.wb_dat_o, 32'd13);

        run(1'b0, 6, 4, 1, 1'b0, "t4_wrap4");
        chk("t4_last", bus.wb_dat_o, mem[5]);

        run(1'b0, 1000, 1, 0, 1'b1, "t5_oor");
        chk("t5_oor_dat", bus.wb_dat_o, 32'h0);
        run(1'b0, 998, 3, 0, 1'b0, "t5_burst");
        run(1'b0, 998, 4, 1, 1'b0, "t5_wrap");

        // Reset lands on the second beat of a write burst.
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = AW'(20); bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'h1111_2020;
        bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b00;
        tick();
        chk("t6_ack0", 32'(bus.wb_ack_o), 32'h1);
        model_write(20, 32'h1111_2020, 4'hF);
        tick();
        bus.wb_adr_i = AW'(21); bus.wb_dat_i = 32'h2222_2121;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ack1", 32'(bus.wb_ack_o), 32'h0);
        chk("t6_err1", 32'(bus.wb_err_o), 32'h0);
        chk("t6_dat1", bus.wb_dat_o, 32'h0);
        run(1'b0, 21, 1, 0, 1'b1, "t6_rd21");
        run(1'b0, 20, 1, 0, 1'b1, "t6_rd20");

        for (int t = 0; t < 60; t++) begin
            int len, start, bte;
            bit we, classic;
            we      = 1'($urandom_range(0, 1));
            classic = ($urandom_range(0, 3) == 0);
            len     = classic ? 1 : $urandom_range(1, 20);
            bte     = $urandom_range(0, 3);
            start   = ($urandom_range(0, 4) == 0) ? $urandom_range(980, 1023)
                                                  : $urandom_range(0, 1023);
            for (int i = 0; i < len; i++) begin
                bdat[i] = $urandom;
                bsel[i] = 4'($urandom_range(0, 15));
            end
            run(we, start, len, bte, classic, we ? "rnd_wr" : "rnd_rd");
            if ($urandom_range(0, 2) == 0) tick();
        end

        run(1'b0, 0, 16, 3, 1'b0, "final_rd_a");
        run(1'b0, 496, 24, 0, 1'b0, "final_rd_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
